// File: rtl/edge_window_sequencer.sv
// Raster-order 3x3 window sequencer: fills two line buffers, presents one packed grid
// per interior pixel to the edge detector and tags its registered result with coordinates.
module edge_window_sequencer #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned XW    = $clog2(IMG_W),
  parameter int unsigned YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    cfg_threshold,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic [71:0]   oGrid,
  output logic [7:0]    oThreshold,
  output logic          det_n_rst,
  input  logic          isEdge,
  output logic          edge_valid,
  output logic          edge_out,
  output logic [XW-1:0] edge_x,
  output logic [YW-1:0] edge_y,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [7:0]      thr_q, thr_d;
  logic [2:0][7:0] col0_q, col0_d;
  logic [2:0][7:0] col1_q, col1_d;
  logic [71:0]     grid_q, grid_d;
  logic            stb_q, stb_d;
  logic [XW-1:0]   tag_x_q, tag_x_d;
  logic [YW-1:0]   tag_y_q, tag_y_d;
  logic            ev_q, ev_d;
  logic [XW-1:0]   ex_q, ex_d;
  logic [YW-1:0]   ey_q, ey_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [7:0]      lb0_q [IMG_W];
  logic [7:0]      lb1_q [IMG_W];

  logic            accept;
  logic            last_col;
  logic            last_row;
  logic            win_ok;
  logic [2:0][7:0] new_col;

  // Row index 0 is the top (oldest line), 2 the bottom (current line).
  assign accept   = pix_valid & ready_q;
  assign last_col = (x_q == XW'(IMG_W - 1));
  assign last_row = (y_q == YW'(IMG_H - 1));
  assign win_ok   = (x_q >= XW'(2)) && (y_q >= YW'(2));
  assign new_col  = {pix_data, lb0_q[x_q], lb1_q[x_q]};

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      thr_q   <= '0;
      col0_q  <= '0;
      col1_q  <= '0;
      grid_q  <= '0;
      stb_q   <= 1'b0;
      tag_x_q <= '0;
      tag_y_q <= '0;
      ev_q    <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      thr_q   <= thr_d;
      col0_q  <= col0_d;
      col1_q  <= col1_d;
      grid_q  <= grid_d;
      stb_q   <= stb_d;
      tag_x_q <= tag_x_d;
      tag_y_q <= tag_y_d;
      ev_q    <= ev_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Line buffers carry no reset; they are refilled before any window is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= pix_data;
    end
  end

  // Next-state, counters, window shift and tag pipeline.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    thr_d   = thr_q;
    col0_d  = col0_q;
    col1_d  = col1_q;
    grid_d  = grid_q;
    stb_d   = 1'b0;
    tag_x_d = tag_x_q;
    tag_y_d = tag_y_q;
    ev_d    = stb_q;
    ex_d    = tag_x_q;
    ey_d    = tag_y_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          thr_d   = cfg_threshold;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          col1_d = col0_q;
          col0_d = new_col;
          if (win_ok) begin
            stb_d   = 1'b1;
            tag_x_d = x_q - XW'(1);
            tag_y_d = y_q - YW'(1);
            // Byte 3r+c: column 0 is the newest pixel, column 2 the oldest.
            for (int r = 0; r < 3; r++) begin
              grid_d[8*(3*r)   +: 8] = new_col[r];
              grid_d[8*(3*r+1) +: 8] = col0_q[r];
              grid_d[8*(3*r+2) +: 8] = col1_q[r];
            end
          end
          if (last_col) begin
            x_d = '0;
            if (last_row) begin
              y_d     = '0;
              state_d = S_DRAIN;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DRAIN: begin
        // The last result leaves stage two while stage one is already empty.
        if (ev_q && !stb_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready_d = (state_d == S_RUN);
  assign busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
  assign done_d  = (state_d == S_DONE);

  // The detector registers its own result, so the decision is forwarded as-is.
  assign pix_ready  = ready_q;
  assign oGrid      = grid_q;
  assign oThreshold = thr_q;
  assign det_n_rst  = ~rst;
  assign edge_valid = ev_q;
  assign edge_out   = ev_q & isEdge;
  assign edge_x     = ex_q;
  assign edge_y     = ey_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_edge_window_sequencer.sv
// Randomized bench for edge_window_sequencer on a 4x4 frame with a behavioural
// Sobel-style detector and an image-coordinate reference model.
module tb_edge_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam logic [71:0] GRID_EX = {8'd8, 8'd9, 8'd10, 8'd4, 8'd5, 8'd6, 8'd0, 8'd1, 8'd2};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    cfg_threshold;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_ready;
  logic [71:0]   oGrid;
  logic [7:0]    oThreshold;
  logic          det_n_rst;
  logic          isEdge = 1'b0;
  logic          edge_valid;
  logic          edge_out;
  logic [XW-1:0] edge_x;
  logic [YW-1:0] edge_y;
  logic          busy;
  logic          done;

  edge_window_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_threshold(cfg_threshold),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .oGrid(oGrid), .oThreshold(oThreshold), .det_n_rst(det_n_rst),
    .isEdge(isEdge), .edge_valid(edge_valid), .edge_out(edge_out),
    .edge_x(edge_x), .edge_y(edge_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int ev_cnt   = 0;
  int last_ev  = 0;
  int n_done   = 0;
  logic done_expected = 1'b0;
  logic lit_check     = 1'b0;
  logic [7:0]  exp_thr   = 8'd0;
  logic [71:0] prev_grid = '0;

  logic [7:0]  img [N];
  int          exp_x [$];
  int          exp_y [$];
  logic        exp_e [$];
  logic [71:0] exp_g [$];
  int          lat_q [$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sobel magnitude |gx|+|gy| compared against the threshold.
  function automatic logic ref_edge(input logic [71:0] g, input logic [7:0] thr);
    int p [9];
    int gx;
    int gy;
    for (int k = 0; k < 9; k++) p[k] = int'(g[8*k +: 8]);
    gx = (p[0] + 2*p[3] + p[6]) - (p[2] + 2*p[5] + p[8]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy) > int'(thr);
  endfunction

  // 3x3 neighbourhood of centre (cx,cy) taken straight from the image.
  function automatic logic [71:0] grid_of(input int cx, input int cy);
    logic [71:0] g;
    g = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[8*(3*r+c) +: 8] = img[(cy - 1 + r) * W + (cx + 1 - c)];
    return g;
  endfunction

  task automatic prepare(input logic [7:0] thr);
    logic [71:0] g;
    for (int cy = 1; cy <= H - 2; cy++)
      for (int cx = 1; cx <= W - 2; cx++) begin
        g = grid_of(cx, cy);
        exp_x.push_back(cx);
        exp_y.push_back(cy);
        exp_g.push_back(g);
        exp_e.push_back(ref_edge(g, thr));
      end
  endtask

  // Detector stand-in: registered decision one cycle after oGrid.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    isEdge <= ref_edge(oGrid, oThreshold);
  end

  always @(negedge clk) begin
    int lc;
    if (!rst && pix_valid && pix_ready) begin
      if ((acc_cnt % W) >= 2 && (acc_cnt / W) >= 2) lat_q.push_back(cyc);
      acc_cnt++;
    end
    if (edge_valid) begin
      if (exp_x.size() == 0 || lat_q.size() == 0) begin
        check("unexpected_edge_valid", 72'(1), 72'(0));
      end else begin
        lc = lat_q.pop_front();
        check("edge_x", 72'(edge_x), 72'(exp_x.pop_front()));
        check("edge_y", 72'(edge_y), 72'(exp_y.pop_front()));
        check("edge_out", 72'(edge_out), 72'(exp_e.pop_front()));
        check("grid", prev_grid, exp_g.pop_front());
        check("latency", 72'(cyc - lc), 72'(2));
        check("threshold_hold", 72'(oThreshold), 72'(exp_thr));
        if (lit_check) begin
          check("grid_example", prev_grid, GRID_EX);
          lit_check = 1'b0;
        end
      end
      ev_cnt++;
      last_ev = cyc;
    end
    if (done) begin
      n_done++;
      check("done_expected", 72'(done_expected), 72'(1));
      check("done_after_last", 72'(cyc - last_ev), 72'(1));
      check("results_per_frame", 72'(ev_cnt), 72'((W - 2) * (H - 2)));
      check("threshold_at_done", 72'(oThreshold), 72'(exp_thr));
      done_expected = 1'b0;
      ev_cnt = 0;
    end
    prev_grid = oGrid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] thr);
    cfg_threshold = thr;
    start   = 1'b1;
    acc_cnt = 0;
    ev_cnt  = 0;
    exp_thr = thr;
    tick();
    start = 1'b0;
    check("busy_after_start", 72'(busy), 72'(1));
    check("ready_after_start", 72'(pix_ready), 72'(1));
  endtask

  task automatic feed(input int unsigned stall, input logic inj, input logic poke);
    int i = 0;
    int guard = 0;
    while (i < N && guard < 4000) begin
      pix_valid = ($urandom_range(99) >= stall);
      pix_data  = img[i];
      if (inj) start = ($urandom_range(3) == 0);
      if (poke && i >= N / 2) cfg_threshold = 8'd0;
      @(negedge clk);
      if (pix_valid && pix_ready) i++;
      tick();
      guard++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (i < N) check("feed_timeout", 72'(i), 72'(N));
  endtask

  task automatic wait_done(input logic chain, input logic [7:0] next_thr);
    int k = 0;
    done_expected = 1'b1;
    @(negedge clk);
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 72'(0), 72'(1));
    if (chain) begin
      cfg_threshold = next_thr;
      start = 1'b1;
      tick();
      check("start_in_done_ignored", 72'(busy), 72'(0));
      acc_cnt = 0;
      tick();
      start = 1'b0;
      check("start_after_done", 72'(busy), 72'(1));
      exp_thr = next_thr;
    end else begin
      tick();
    end
  endtask

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; cfg_threshold = 8'd0;
    repeat (3) tick();
    check("rst_pix_ready", 72'(pix_ready), 72'(0));
    check("rst_oGrid", oGrid, 72'(0));
    check("rst_oThreshold", 72'(oThreshold), 72'(0));
    check("rst_edge_valid", 72'(edge_valid), 72'(0));
    check("rst_edge_out", 72'(edge_out), 72'(0));
    check("rst_edge_xy", 72'({edge_x, edge_y}), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_done", 72'(done), 72'(0));
    check("det_n_rst_low", 72'(det_n_rst), 72'(0));
    rst = 1'b0;
    tick();
    check("det_n_rst_high", 72'(det_n_rst), 72'(1));

    // Ramp image, continuous valid.
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    prepare(8'd10);
    lit_check = 1'b1;
    start_frame(8'd10);
    feed(0, 1'b0, 1'b0);
    wait_done(1'b0, 8'd0);

    // Vertical step with stalls, stray starts, threshold poke; chain a frame off done.
    for (int i = 0; i < N; i++) img[i] = ((i % W) >= 2) ? 8'd200 : 8'd0;
    prepare(8'd100);
    start_frame(8'd100);
    feed(50, 1'b1, 1'b1);
    wait_done(1'b1, 8'd77);
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
    prepare(8'd77);
    feed(30, 1'b0, 1'b0);
    wait_done(1'b0, 8'd0);

    // Ramp again under heavy stalls.
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    prepare(8'd10);
    start_frame(8'd10);
    feed(50, 1'b0, 1'b0);
    wait_done(1'b0, 8'd0);

    // Reset mid-frame with a window result in flight.
    start_frame(8'd50);
    pix_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      pix_data = img[i];
      tick();
    end
    pix_valid = 1'b0;
    nd = n_done;
    rst = 1'b1;
    tick();
    check("midrst_busy", 72'(busy), 72'(0));
    check("midrst_ready", 72'(pix_ready), 72'(0));
    check("midrst_edge_valid", 72'(edge_valid), 72'(0));
    tick();
    tick();
    rst = 1'b0;
    lat_q.delete();
    repeat (12) tick();
    check("midrst_no_done", 72'(n_done), 72'(nd));

    // Clean frame after reset.
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
    prepare(8'd60);
    start_frame(8'd60);
    feed(20, 1'b0, 1'b0);
    wait_done(1'b0, 8'd0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
